// File: rtl/btn_debounce_rpt.sv
// Push-button conditioner: synchronizes raw pins, debounces them on the 10 Hz
// tick and produces a clean level, a press pulse and an auto-repeat pulse per button.
module btn_debounce_rpt #(
    parameter int N_BTN          = 4,
    parameter int ACTIVE_LOW     = 1,
    parameter int STABLE_SAMPLES = 2,
    parameter int REPEAT_DELAY   = 10,
    parameter int REPEAT_RATE    = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             debclk_10hz,
    input  logic [N_BTN-1:0] btn_in,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_press,
    output logic [N_BTN-1:0] btn_repeat
);

    localparam int HOLD_TOP = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int SW       = $clog2(STABLE_SAMPLES + 1);
    localparam int HW       = $clog2(HOLD_TOP + 1);

    localparam logic [SW-1:0]    STAB_ZERO    = {SW{1'b0}};
    localparam logic [SW-1:0]    STAB_ONE     = SW'(1);
    localparam logic [SW-1:0]    STAB_LIM     = SW'(STABLE_SAMPLES);
    localparam logic [SW-1:0]    STAB_MAX     = {SW{1'b1}};
    localparam logic [HW-1:0]    HOLD_ZERO    = {HW{1'b0}};
    localparam logic [HW-1:0]    HOLD_ONE     = HW'(1);
    localparam logic [HW-1:0]    HOLD_DLY     = HW'(REPEAT_DELAY);
    localparam logic [HW-1:0]    HOLD_RATE    = HW'(REPEAT_RATE);
    localparam logic [HW-1:0]    HOLD_MAX     = {HW{1'b1}};
    localparam logic             RPT_EN       = (REPEAT_DELAY != 0);
    localparam logic [N_BTN-1:0] PIN_RELEASED = (ACTIVE_LOW != 0) ? {N_BTN{1'b1}} : {N_BTN{1'b0}};

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_PRESS_W = 3'd1,
        ST_HELD    = 3'd2,
        ST_RPT     = 3'd3,
        ST_REL_W   = 3'd4
    } state_t;

    logic [N_BTN-1:0] sync_1_r;
    logic [N_BTN-1:0] sync_2_r;
    logic [N_BTN-1:0] samp_s;
    logic             deb_d_r;
    logic             tick_s;

    // Pin synchronizer and debounce-clock edge history
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_1_r <= PIN_RELEASED;
            sync_2_r <= PIN_RELEASED;
            deb_d_r  <= 1'b1;
        end else begin
            sync_1_r <= btn_in;
            sync_2_r <= sync_1_r;
            deb_d_r  <= debclk_10hz;
        end
    end

    // deb_d_r resets high so the first tick needs a genuine rising edge
    assign tick_s = debclk_10hz & ~deb_d_r;
    assign samp_s = (ACTIVE_LOW != 0) ? ~sync_2_r : sync_2_r;

    for (genvar gi = 0; gi < N_BTN; gi++) begin : g_btn
        state_t        state_r, state_s;
        logic [SW-1:0] stab_r, stab_s, stab_inc_s;
        logic [HW-1:0] hold_r, hold_s, hold_inc_s;
        logic          level_r, level_s;
        logic          press_r, press_s;
        logic          rpt_r, rpt_s;

        assign stab_inc_s = (stab_r == STAB_MAX) ? stab_r : stab_r + STAB_ONE;
        assign hold_inc_s = (hold_r == HOLD_MAX) ? hold_r : hold_r + HOLD_ONE;

        // Debounce / repeat next-state and output decode, evaluated only on tick
        always_comb begin
            state_s = state_r;
            stab_s  = stab_r;
            hold_s  = hold_r;
            level_s = level_r;
            press_s = 1'b0;
            rpt_s   = 1'b0;
            if (tick_s) begin
                case (state_r)
                    ST_IDLE, ST_PRESS_W: begin
                        if (samp_s[gi]) begin
                            if (stab_inc_s == STAB_LIM) begin
                                state_s = ST_HELD;
                                stab_s  = STAB_ZERO;
                                hold_s  = HOLD_ZERO;
                                level_s = 1'b1;
                                press_s = 1'b1;
                            end else begin
                                state_s = ST_PRESS_W;
                                stab_s  = stab_inc_s;
                            end
                        end else begin
                            state_s = ST_IDLE;
                            stab_s  = STAB_ZERO;
                        end
                    end
                    ST_HELD, ST_RPT: begin
                        if (samp_s[gi]) begin
                            hold_s = hold_inc_s;
                            if (RPT_EN && (hold_inc_s == ((state_r == ST_HELD) ? HOLD_DLY : HOLD_RATE))) begin
                                state_s = ST_RPT;
                                hold_s  = HOLD_ZERO;
                                rpt_s   = 1'b1;
                            end else begin
                                state_s = state_r;
                            end
                        end else if (STAB_ONE == STAB_LIM) begin
                            // a single released sample already satisfies the release count
                            state_s = ST_IDLE;
                            stab_s  = STAB_ZERO;
                            hold_s  = HOLD_ZERO;
                            level_s = 1'b0;
                        end else begin
                            state_s = ST_REL_W;
                            stab_s  = STAB_ONE;
                        end
                    end
                    ST_REL_W: begin
                        if (samp_s[gi]) begin
                            state_s = ST_HELD;
                            stab_s  = STAB_ZERO;
                            hold_s  = HOLD_ZERO;
                        end else if (stab_inc_s == STAB_LIM) begin
                            state_s = ST_IDLE;
                            stab_s  = STAB_ZERO;
                            hold_s  = HOLD_ZERO;
                            level_s = 1'b0;
                        end else begin
                            stab_s = stab_inc_s;
                        end
                    end
                    default: begin
                        state_s = ST_IDLE;
                        stab_s  = STAB_ZERO;
                        hold_s  = HOLD_ZERO;
                        level_s = 1'b0;
                    end
                endcase
            end else begin
                state_s = state_r;
            end
        end

        // Per-button state, counters and registered outputs
        always_ff @(posedge clk) begin
            if (rst) begin
                state_r <= ST_IDLE;
                stab_r  <= STAB_ZERO;
                hold_r  <= HOLD_ZERO;
                level_r <= 1'b0;
                press_r <= 1'b0;
                rpt_r   <= 1'b0;
            end else begin
                state_r <= state_s;
                stab_r  <= stab_s;
                hold_r  <= hold_s;
                level_r <= level_s;
                press_r <= press_s;
                rpt_r   <= rpt_s;
            end
        end

        assign btn_level[gi]  = level_r;
        assign btn_press[gi]  = press_r;
        assign btn_repeat[gi] = rpt_r;
    end

endmodule

// File: tb/tb_btn_debounce_rpt.sv
// Self-checking bench for btn_debounce_rpt: directed scenarios plus random pin
// activity, compared cycle by cycle against a run-length reference model.
module tb_btn_debounce_rpt;

    localparam int SS = 2;
    localparam int RD = 10;
    localparam int RR = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       debclk_10hz = 1'b0;
    logic [3:0] btn_in = 4'hF;
    logic [3:0] btn_level, btn_press, btn_repeat;

    btn_debounce_rpt #(
        .N_BTN(4), .ACTIVE_LOW(1), .STABLE_SAMPLES(SS), .REPEAT_DELAY(RD), .REPEAT_RATE(RR)
    ) dut (
        .clk(clk), .rst(rst), .debclk_10hz(debclk_10hz), .btn_in(btn_in),
        .btn_level(btn_level), .btn_press(btn_press), .btn_repeat(btn_repeat)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int errors  = 0;
    int ph      = 0;

    // reference model: pin pipeline plus per-button run lengths
    logic       m_prev_deb = 1'b1;
    logic [3:0] m_s1 = 4'hF, m_s2 = 4'hF;
    logic [3:0] exp_level = 4'h0, exp_press = 4'h0, exp_repeat = 4'h0;
    int         m_pc[4];
    int         m_rc[4];
    int         m_h[4];

    task automatic model_edge();
        logic [3:0] s;
        logic       tk;
        if (rst) begin
            m_prev_deb = 1'b1;
            m_s1 = 4'hF; m_s2 = 4'hF;
            exp_level = 4'h0; exp_press = 4'h0; exp_repeat = 4'h0;
            for (int b = 0; b < 4; b++) begin
                m_pc[b] = 0; m_rc[b] = 0; m_h[b] = 0;
            end
        end else begin
            tk = debclk_10hz & ~m_prev_deb;
            s = ~m_s2;
            exp_press = 4'h0;
            exp_repeat = 4'h0;
            if (tk) begin
                for (int b = 0; b < 4; b++) begin
                    if (!exp_level[b]) begin
                        if (s[b]) begin
                            m_pc[b]++;
                            if (m_pc[b] == SS) begin
                                exp_level[b] = 1'b1; exp_press[b] = 1'b1;
                                m_pc[b] = 0; m_rc[b] = 0; m_h[b] = 0;
                            end
                        end else begin
                            m_pc[b] = 0;
                        end
                    end else if (s[b]) begin
                        if (m_rc[b] > 0) begin
                            m_rc[b] = 0; m_h[b] = 0;
                        end else begin
                            m_h[b]++;
                            if (RD != 0 && m_h[b] >= RD && ((m_h[b] - RD) % RR) == 0)
                                exp_repeat[b] = 1'b1;
                        end
                    end else begin
                        m_rc[b]++;
                        if (m_rc[b] == SS) begin
                            exp_level[b] = 1'b0;
                            m_rc[b] = 0; m_pc[b] = 0; m_h[b] = 0;
                        end
                    end
                end
            end
            m_prev_deb = debclk_10hz;
            m_s2 = m_s1;
            m_s1 = btn_in;
        end
    endtask

    // one clock: model sees the same inputs as the DUT, debclk advances its 20-clk phase
    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        ph = (ph + 1) % 20;
        debclk_10hz = (ph >= 10) ? 1'b1 : 1'b0;
    endtask

    function automatic int edges_to_tick();
        return ((10 - ph + 20) % 20) + 1;
    endfunction

    task automatic test_reset();
        int t = 0, k, press_cnt = 0, press_t = -1;
        rst = 1'b1; btn_in = 4'b1110; ph = 0; debclk_10hz = 1'b0;
        repeat (3) begin
            step();
            vectors++;
            if ({btn_level, btn_press, btn_repeat} !== 12'h000) begin
                errors++;
                $display("FAIL reset_hold got %h exp 000", {btn_level, btn_press, btn_repeat});
            end
        end
        rst = 1'b0;
        while (t < 6) begin
            k = edges_to_tick();
            if (k == 5 && t >= 3) btn_in = 4'hF;
            step();
            if (k == 1) t++;
            vectors++;
            if ({btn_level, btn_press, btn_repeat} !== {exp_level, exp_press, exp_repeat}) begin
                errors++;
                $display("FAIL reset_model t=%0d got %h exp %h", t, {btn_level, btn_press, btn_repeat}, {exp_level, exp_press, exp_repeat});
            end
            if (t < 2) begin
                vectors++;
                if ({btn_level, btn_press, btn_repeat} !== 12'h000) begin
                    errors++;
                    $display("FAIL reset_quiet t=%0d got %h exp 000", t, {btn_level, btn_press, btn_repeat});
                end
            end
            if (btn_press[0]) begin press_cnt++; press_t = t; end
        end
        vectors++;
        if (press_cnt !== 1 || press_t !== 2) begin
            errors++;
            $display("FAIL reset_press count=%0d tick=%0d exp count=1 tick=2", press_cnt, press_t);
        end
    endtask

    task automatic test_clean_press();
        int t = 0, k, press_cnt = 0, rise_t = -1, fall_t = -1;
        while (t < 8) begin
            k = edges_to_tick();
            if (k == 5) btn_in = (t + 1 <= 4) ? 4'b1110 : 4'b1111;
            step();
            if (k == 1) t++;
            vectors++;
            if ({btn_level, btn_press, btn_repeat} !== {exp_level, exp_press, exp_repeat}) begin
                errors++;
                $display("FAIL clean_model t=%0d got %h exp %h", t, {btn_level, btn_press, btn_repeat}, {exp_level, exp_press, exp_repeat});
            end
            if (btn_press[0]) press_cnt++;
            if (btn_level[0] && rise_t < 0) rise_t = t;
            if (!btn_level[0] && rise_t >= 0 && fall_t < 0) fall_t = t;
        end
        vectors++;
        if (press_cnt !== 1 || rise_t !== 2 || fall_t !== 6) begin
            errors++;
            $display("FAIL clean_press presses=%0d rise=%0d fall=%0d exp 1/2/6", press_cnt, rise_t, fall_t);
        end
    endtask

    task automatic test_bounce();
        int t = 0, k, cyc = 0, press_cnt = 0, press_t = -1;
        bit early = 1'b0;
        while (t < 9) begin
            k = edges_to_tick();
            if (k == 5) btn_in[0] = (t + 1 == 1 || t + 1 == 3 || t + 1 == 4) ? 1'b0 : 1'b1;
            else if (k > 5 && (cyc % 3) == 0) btn_in[0] = 1'($urandom_range(0, 1));
            step();
            cyc++;
            if (k == 1) t++;
            vectors++;
            if ({btn_level, btn_press, btn_repeat} !== {exp_level, exp_press, exp_repeat}) begin
                errors++;
                $display("FAIL bounce_model t=%0d got %h exp %h", t, {btn_level, btn_press, btn_repeat}, {exp_level, exp_press, exp_repeat});
            end
            if (btn_press[0]) begin press_cnt++; press_t = t; end
            if (t < 4 && btn_level[0]) early = 1'b1;
        end
        btn_in = 4'hF;
        vectors++;
        if (press_cnt !== 1 || press_t !== 4 || early) begin
            errors++;
            $display("FAIL bounce_press presses=%0d tick=%0d early=%0d exp 1/4/0", press_cnt, press_t, early);
        end
    endtask

    task automatic test_auto_repeat();
        int t = 0, k, press_cnt = 0, press_t = -1;
        logic [31:0] rpt_mask = 32'h0;
        while (t < 23) begin
            k = edges_to_tick();
            if (k == 5) btn_in = (t + 1 <= 20) ? 4'b1101 : 4'b1111;
            step();
            if (k == 1) t++;
            vectors++;
            if ({btn_level, btn_press, btn_repeat} !== {exp_level, exp_press, exp_repeat}) begin
                errors++;
                $display("FAIL repeat_model t=%0d got %h exp %h", t, {btn_level, btn_press, btn_repeat}, {exp_level, exp_press, exp_repeat});
            end
            if (btn_press[1]) begin press_cnt++; press_t = t; end
            if (btn_repeat[1]) rpt_mask[t] = 1'b1;
        end
        vectors++;
        if (press_cnt !== 1 || press_t !== 2 || rpt_mask !== 32'h0015_5000) begin
            errors++;
            $display("FAIL auto_repeat presses=%0d tick=%0d ticks=%h exp 1/2/00155000", press_cnt, press_t, rpt_mask);
        end
    endtask

    task automatic test_release_glitch();
        int t = 0, k, press_cnt = 0;
        bit dropped = 1'b0;
        logic [31:0] rpt_mask = 32'h0;
        while (t < 29) begin
            k = edges_to_tick();
            if (k == 5) btn_in = (t + 1 == 13 || t + 1 > 26) ? 4'b1111 : 4'b1011;
            step();
            if (k == 1) t++;
            vectors++;
            if ({btn_level, btn_press, btn_repeat} !== {exp_level, exp_press, exp_repeat}) begin
                errors++;
                $display("FAIL glitch_model t=%0d got %h exp %h", t, {btn_level, btn_press, btn_repeat}, {exp_level, exp_press, exp_repeat});
            end
            if (btn_press[2]) press_cnt++;
            if (btn_repeat[2]) rpt_mask[t] = 1'b1;
            if (t >= 2 && t < 28 && !btn_level[2]) dropped = 1'b1;
        end
        vectors++;
        if (press_cnt !== 1 || dropped || rpt_mask !== 32'h0500_1000) begin
            errors++;
            $display("FAIL release_glitch presses=%0d dropped=%0d ticks=%h exp 1/0/05001000", press_cnt, dropped, rpt_mask);
        end
    endtask

    task automatic test_multi_reset();
        int t = 0, k, cyc = 0;
        int p0_first = -1, p3_first = -1, p0_second = -1, p3_second = -1, c0 = -1, c3 = -1;
        bit did_rst;
        while (t < 12) begin
            k = edges_to_tick();
            did_rst = 1'b0;
            if (k == 5) btn_in = (t + 1 <= 9) ? 4'b0110 : 4'b1111;
            if (k == 1 && t == 4) begin rst = 1'b1; did_rst = 1'b1; end
            step();
            rst = 1'b0;
            cyc++;
            if (k == 1) t++;
            vectors++;
            if ({btn_level, btn_press, btn_repeat} !== {exp_level, exp_press, exp_repeat}) begin
                errors++;
                $display("FAIL multi_model t=%0d got %h exp %h", t, {btn_level, btn_press, btn_repeat}, {exp_level, exp_press, exp_repeat});
            end
            if (did_rst) begin
                vectors++;
                if ({btn_level, btn_press, btn_repeat} !== 12'h000) begin
                    errors++;
                    $display("FAIL multi_reset_clear got %h exp 000", {btn_level, btn_press, btn_repeat});
                end
            end
            if (btn_press[0]) begin
                if (p0_first < 0) begin p0_first = t; c0 = cyc; end else p0_second = t;
            end
            if (btn_press[3]) begin
                if (p3_first < 0) begin p3_first = t; c3 = cyc; end else p3_second = t;
            end
        end
        vectors++;
        if (p0_first !== 2 || p3_first !== 2 || c0 !== c3) begin
            errors++;
            $display("FAIL multi_same_cycle ticks=%0d/%0d cycles=%0d/%0d exp 2/2 equal", p0_first, p3_first, c0, c3);
        end
        vectors++;
        if (p0_second !== 7 || p3_second !== 7) begin
            errors++;
            $display("FAIL multi_repress ticks=%0d/%0d exp 7/7", p0_second, p3_second);
        end
    endtask

    task automatic test_random();
        int idx;
        for (int c = 0; c < 2000; c++) begin
            if ($urandom_range(0, 63) == 0) begin
                idx = $urandom_range(0, 3);
                btn_in[idx] = ~btn_in[idx];
            end
            rst = ($urandom_range(0, 499) == 0) ? 1'b1 : 1'b0;
            step();
            rst = 1'b0;
            vectors++;
            if ({btn_level, btn_press, btn_repeat} !== {exp_level, exp_press, exp_repeat}) begin
                errors++;
                $display("FAIL random_model cyc=%0d got %h exp %h", c, {btn_level, btn_press, btn_repeat}, {exp_level, exp_press, exp_repeat});
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_clean_press();
        test_bounce();
        test_auto_repeat();
        test_release_glitch();
        test_multi_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
